mlcd_frame_writer: RTL



---
 rtl/mlcd_frame_writer_pkg.sv | 75 +++++++
 rtl/mlcd_frame_writer_if.sv | 37 +++
 rtl/mlcd_frame_writer_beat.sv | 59 +++++
 rtl/mlcd_frame_writer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlcd_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlcd_pkg
// Description : Shared types, command constants and beat-sequencing helpers
//               for the 8080 MCU LCD frame writer.
//               Contents: state_t (frame FSM states), cmd_mode_t (command
//               address style), beat_t (rs + 16-bit bus word), helpers that
//               build the address-set beat sequences.
// Revision    : 1.0 - initial release
// ============================================================================
package mlcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_COL  = 3'd1,
    ST_SET_PAGE = 3'd2,
    ST_GRAM_CMD = 3'd3,
    ST_PIXEL    = 3'd4,
    ST_LINE_GAP = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Address style: DCS sends one command then all params; SUB sends a
  // sub-addressed command (cmd<<8 | k) in front of every param k.
  typedef enum logic {
    MODE_DCS = 1'b0,
    MODE_SUB = 1'b1
  } cmd_mode_t;

  localparam logic [7:0] CMD_COL  = 8'h2A;
  localparam logic [7:0] CMD_PAGE = 8'h2B;
  localparam logic [7:0] CMD_GRAM = 8'h2C;

  typedef struct packed {
    logic        rs;
    logic [15:0] word;
  } beat_t;

  // Inclusive end coordinate; one extra bit so x0+w-1 never wraps.
  function automatic logic [11:0] end_coord(logic [10:0] origin, logic [10:0] size);
    return {1'b0, origin} + {1'b0, size} - 12'd1;
  endfunction

  // Index of the final beat of an address-set group.
  function automatic logic [2:0] set_last_idx(cmd_mode_t mode);
    return (mode == MODE_SUB) ? 3'd7 : 3'd4;
  endfunction

  function automatic logic [15:0] gram_word(cmd_mode_t mode);
    return (mode == MODE_SUB) ? {CMD_GRAM, 8'h00} : {8'h00, CMD_GRAM};
  endfunction

  // Beat idx of an address-set group for the span [s, e].
  // Params, in order: s[15:8], s[7:0], e[15:8], e[7:0], each zero-extended.
  function automatic beat_t set_beat(cmd_mode_t mode, logic [7:0] cmd,
                                     logic [2:0] idx, logic [10:0] s,
                                     logic [11:0] e);
    beat_t      b;
    logic [1:0] k;
    k    = (mode == MODE_SUB) ? idx[2:1] : 2'(idx - 3'd1);
    b.rs = (mode == MODE_SUB) ? idx[0] : (idx != 3'd0);
    case (k)
      2'd0:    b.word = {13'd0, s[10:8]};
      2'd1:    b.word = {8'd0, s[7:0]};
      2'd2:    b.word = {12'd0, e[11:8]};
      default: b.word = {8'd0, e[7:0]};
    endcase
    if (!b.rs) begin
      b.word = (mode == MODE_SUB) ? {cmd, 6'd0, idx[2:1]} : {8'd0, cmd};
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mlcd_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : mlcd_frame_writer_if
// Description : Pixel FIFO read port plus 8080 LCD pin bundle.
//               master : the frame writer (pops FIFO, drives LCD pins)
//               slave  : the FIFO / LCD side
//               Signals: pixel_data, fifo_empty, rd_en, mlcd_cs, mlcd_rd,
//               mlcd_rst, mlcd_bl, mlcd_wr, mlcd_rs, mlcd_data.
// Revision    : 1.0 - initial release
// ============================================================================
interface mlcd_frame_writer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] pixel_data;
  logic              fifo_empty;
  logic              rd_en;
  logic              mlcd_cs;
  logic              mlcd_rd;
  logic              mlcd_rst;
  logic              mlcd_bl;
  logic              mlcd_wr;
  logic              mlcd_rs;
  logic [DATA_W-1:0] mlcd_data;

  modport master (
    input  pixel_data, fifo_empty,
    output rd_en, mlcd_cs, mlcd_rd, mlcd_rst, mlcd_bl,
    output mlcd_wr, mlcd_rs, mlcd_data
  );

  modport slave (
    output pixel_data, fifo_empty,
    input  rd_en, mlcd_cs, mlcd_rd, mlcd_rst, mlcd_bl,
    input  mlcd_wr, mlcd_rs, mlcd_data
  );
endinterface
`default_nettype wire

// File: rtl/mlcd_frame_writer_beat.sv
`default_nettype none
// ============================================================================
// Module      : mlcd_beat
// Description : One 8080 write beat: WR_LOW cycles of wr=0 followed by
//               WR_HIGH cycles of wr=1. rs/data latch at launch and hold.
//   clk, rst_n       : clock, async active-low reset
//   launch           : start a beat (only honoured when ready)
//   beat_rs/beat_data: values to place on the bus for this beat
//   wr, rs, data     : registered LCD pins
//   ready            : no beat in flight; a launch this cycle is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module mlcd_beat #(
  parameter int DATA_W  = 16,
  parameter int WR_LOW  = 1,
  parameter int WR_HIGH = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              launch,
  input  wire logic              beat_rs,
  input  wire logic [DATA_W-1:0] beat_data,
  output logic                   wr,
  output logic                   rs,
  output logic [DATA_W-1:0]      data,
  output logic                   ready
);

  localparam int PERIOD = WR_LOW + WR_HIGH;
  localparam int CNT_W  = $clog2(PERIOD + 1);

  // cnt = cycles left in the current beat; zero means idle.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_dec;

  assign w_cnt_dec = r_cnt - 1'b1;
  assign ready     = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      wr    <= 1'b1;
      rs    <= 1'b0;
      data  <= '0;
    end else if (launch && ready) begin
      r_cnt <= CNT_W'(PERIOD - 1);
      wr    <= 1'b0;
      rs    <= beat_rs;
      data  <= beat_data;
    end else if (!ready) begin
      r_cnt <= w_cnt_dec;
      // Low phase occupies the first WR_LOW cycles, i.e. while the
      // remaining count is still >= WR_HIGH.
      wr    <= (w_cnt_dec < CNT_W'(WR_HIGH));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mlcd_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : mlcd_frame_writer
// Description : Per frame: column/page address-set, write-GRAM, then streams
//               win_w*win_h pixels from a FWFT FIFO onto an 8080 LCD bus.
//   clk, rst_n           : clock, async active-low reset
//   lcd_init_done        : level enable; dropping it aborts the frame
//   cmd_mode             : 0 DCS commands, 1 sub-addressed commands
//   win_x0/y0, win_w/h   : window origin and size (sampled per frame)
//   bus (master)         : FIFO read port and LCD pins
//   busy                 : frame in progress
//   frame_done           : one-cycle pulse after the final pixel beat
// Revision    : 1.0 - initial release
// ============================================================================
module mlcd_frame_writer
  import mlcd_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int WR_LOW   = 1,
  parameter int WR_HIGH  = 1,
  parameter int LINE_GAP = 0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        lcd_init_done,
  input  wire logic        cmd_mode,
  input  wire logic [10:0] win_x0,
  input  wire logic [10:0] win_y0,
  input  wire logic [10:0] win_w,
  input  wire logic [10:0] win_h,
  mlcd_frame_writer_if.master bus,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [10:0] GAP_LAST = (LINE_GAP > 0) ? 11'(LINE_GAP - 1) : 11'd0;

  state_t      r_state;
  cmd_mode_t   r_mode;
  logic [10:0] r_x0, r_y0, r_w, r_h;
  logic [11:0] r_xe, r_ye;
  logic [2:0]  r_idx;
  logic [10:0] r_col, r_row, r_gap_cnt;
  logic        r_req;
  logic        r_abort;
  logic        r_cmd_rs;
  logic [15:0] r_cmd_word;

  logic              w_ready;
  logic              w_pixel_phase;
  logic              w_launch;
  logic              w_beat_rs;
  logic [DATA_W-1:0] w_beat_data;
  logic              w_wr, w_rs;
  logic [DATA_W-1:0] w_data;
  cmd_mode_t         w_mode_in;
  logic [11:0]       w_xe_in;

  assign w_mode_in = cmd_mode_t'(cmd_mode);
  assign w_xe_in   = end_coord(win_x0, win_w);

  // Pixel beats also wait on FIFO data; lcd_init_done gates every launch so
  // nothing is popped once it falls.
  assign w_pixel_phase = (r_state == ST_PIXEL);
  assign w_launch      = r_req && w_ready && lcd_init_done &&
                         !(w_pixel_phase && bus.fifo_empty);
  assign w_beat_rs     = w_pixel_phase ? 1'b1 : r_cmd_rs;
  assign w_beat_data   = w_pixel_phase ? bus.pixel_data : DATA_W'(r_cmd_word);

  assign bus.rd_en     = w_launch && w_pixel_phase;
  assign bus.mlcd_cs   = 1'b0;
  assign bus.mlcd_rd   = 1'b1;
  assign bus.mlcd_rst  = 1'b1;
  assign bus.mlcd_bl   = 1'b1;
  assign bus.mlcd_wr   = w_wr;
  assign bus.mlcd_rs   = w_rs;
  assign bus.mlcd_data = w_data;

  mlcd_beat #(
    .DATA_W  (DATA_W),
    .WR_LOW  (WR_LOW),
    .WR_HIGH (WR_HIGH)
  ) u_beat (
    .clk       (clk),
    .rst_n     (rst_n),
    .launch    (w_launch),
    .beat_rs   (w_beat_rs),
    .beat_data (w_beat_data),
    .wr        (w_wr),
    .rs        (w_rs),
    .data      (w_data),
    .ready     (w_ready)
  );

  // r_req/r_cmd_* always describe the next beat to send; a launch advances
  // them so command beats run back-to-back at one per beat period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_DCS;
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_xe       <= '0;
      r_ye       <= '0;
      r_idx      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_gap_cnt  <= '0;
      r_req      <= 1'b0;
      r_abort    <= 1'b0;
      r_cmd_rs   <= 1'b0;
      r_cmd_word <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (r_state != ST_IDLE && (!lcd_init_done || r_abort)) begin
        // Abort: let the in-flight beat finish, then park in IDLE silently.
        r_req <= 1'b0;
        if (w_ready) begin
          r_state <= ST_IDLE;
          r_abort <= 1'b0;
          busy    <= 1'b0;
        end else begin
          r_abort <= 1'b1;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (lcd_init_done && win_w != 11'd0 && win_h != 11'd0) begin
              r_mode  <= w_mode_in;
              r_x0    <= win_x0;
              r_y0    <= win_y0;
              r_w     <= win_w;
              r_h     <= win_h;
              r_xe    <= w_xe_in;
              r_ye    <= end_coord(win_y0, win_h);
              r_idx   <= 3'd0;
              {r_cmd_rs, r_cmd_word} <= set_beat(w_mode_in, CMD_COL, 3'd0, win_x0, w_xe_in);
              r_req   <= 1'b1;
              busy    <= 1'b1;
              r_state <= ST_SET_COL;
            end
          end
          ST_SET_COL: begin
            if (w_launch) begin
              if (r_idx == set_last_idx(r_mode)) begin
                r_idx   <= 3'd0;
                {r_cmd_rs, r_cmd_word} <= set_beat(r_mode, CMD_PAGE, 3'd0, r_y0, r_ye);
                r_state <= ST_SET_PAGE;
              end else begin
                r_idx <= r_idx + 3'd1;
                {r_cmd_rs, r_cmd_word} <= set_beat(r_mode, CMD_COL, r_idx + 3'd1, r_x0, r_xe);
              end
            end
          end
          ST_SET_PAGE: begin
            if (w_launch) begin
              if (r_idx == set_last_idx(r_mode)) begin
                r_cmd_rs   <= 1'b0;
                r_cmd_word <= gram_word(r_mode);
                r_state    <= ST_GRAM_CMD;
              end else begin
                r_idx <= r_idx + 3'd1;
                {r_cmd_rs, r_cmd_word} <= set_beat(r_mode, CMD_PAGE, r_idx + 3'd1, r_y0, r_ye);
              end
            end
          end
          ST_GRAM_CMD: begin
            if (w_launch) begin
              r_col   <= '0;
              r_row   <= '0;
              r_state <= ST_PIXEL;
            end
          end
          ST_PIXEL: begin
            if (w_launch) begin
              if (r_col == r_w - 11'd1) begin
                r_col <= '0;
                if (LINE_GAP > 0) begin
                  // Row advances when the gap ends.
                  r_req     <= 1'b0;
                  r_gap_cnt <= '0;
                  r_state   <= ST_LINE_GAP;
                end else if (r_row == r_h - 11'd1) begin
                  r_req   <= 1'b0;
                  r_state <= ST_DONE;
                end else begin
                  r_row <= r_row + 11'd1;
                end
              end else begin
                r_col <= r_col + 11'd1;
              end
            end
          end
          ST_LINE_GAP: begin
            // Gap counts idle cycles after the line's last beat completes.
            if (w_ready) begin
              if (r_gap_cnt == GAP_LAST) begin
                if (r_row == r_h - 11'd1) begin
                  r_state <= ST_DONE;
                end else begin
                  r_row   <= r_row + 11'd1;
                  r_req   <= 1'b1;
                  r_state <= ST_PIXEL;
                end
              end else begin
                r_gap_cnt <= r_gap_cnt + 11'd1;
              end
            end
          end
          ST_DONE: begin
            if (w_ready) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
          default: begin
            r_req   <= 1'b0;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
